ray_plane_num_den: RTL and testbench
====================================

// Module: ray_plane_num_den
// PURPOSE
//  Upstream operand stage for divide_module in the ray/plane intersection path (t = num/den).
//  Pops one ray/plane record from an input FIFO.
//  Computes num = N.(P0-O) and den = N.D in signed Q fixed point, using one shared multiplier over 6 cycles.
//  Pushes {num, den, parallel} into the FIFO that feeds the divider's dividend/divisor ports.
// PARAMETERS
//  Q_BITS  10  fractional bits of every fixed-point operand and result (1.0 = 2**Q_BITS)
//  D_BITS  32  signed width of every vector component and of num_out/den_out
// PORTS
//  clock        in   1         rising-edge clock
//  reset        in   1         asynchronous, active-high
//  ray_o        in   3*D_BITS  ray origin {z,y,x}, signed Q; valid while !in_empty
//  ray_d        in   3*D_BITS  ray direction {z,y,x}, signed Q
//  pln_n        in   3*D_BITS  plane normal {z,y,x}, signed Q
//  pln_p        in   3*D_BITS  point on plane {z,y,x}, signed Q
//  in_empty     in   1         input FIFO empty (first-word-fall-through)
//  in_rd_en     out  1         pop strobe, one cycle per record
//  num_out      out  D_BITS    saturated N.(P0-O), signed Q
//  den_out      out  D_BITS    saturated N.D, signed Q
//  parallel     out  1         den_out == 0; divider result must be discarded
//  out_full     in   1         output FIFO full
//  out_wr_en    out  1         push strobe
// BEHAVIOUR
//  Reset: state IDLE; all internal registers cleared.
//   in_rd_en, out_wr_en, num_out, den_out and parallel all drive 0.
//  Outputs are combinational from the state. num_out/den_out/parallel are 0 in every state except WRITE.
//  IDLE:
//   - If !in_empty: assert in_rd_en, latch all four vectors, go to SUB.
//   - Otherwise stay in IDLE with no strobes.
//  SUB (1 cycle):
//   - diff[i] = pln_p[i] - ray_o[i], held at D_BITS+1 signed bits (no overflow).
//   - Clear both accumulators, set k=0, go to MAC.
//  MAC (6 cycles, k = 0..5; one signed multiply per cycle):
//   - k = 0..2: acc_num += n[k]*diff[k]
//   - k = 3..5: acc_den += n[k-3]*d[k-3]
//   - Products are (2*D_BITS+1) bits; accumulators are 2*D_BITS+3 bits. No intermediate truncation.
//   - After k=5, go to WRITE.
//  Result formation (combinational into WRITE):
//   - r = acc >>> Q_BITS (arithmetic shift, floor rounding).
//   - Saturate r to [-(2**(D_BITS-1)-1), 2**(D_BITS-1)-1]. The most negative code is never emitted, so the
//     divider's sign-magnitude negation is always safe.
//   - parallel = (saturated den == 0).
//  WRITE:
//   - If !out_full: assert out_wr_en for exactly one cycle with valid data, go to IDLE.
//   - If out_full: hold results and stay in WRITE. No further in_rd_en until the push completes.
//  Latency and throughput:
//   - in_rd_en in cycle T gives out_wr_en no earlier than cycle T+8.
//   - Throughput is 1 record per 9 cycles. No overlap between records.
//  in_rd_en and out_wr_en are never high in the same cycle.
//  Reset mid-operation: the in-flight record is discarded, no out_wr_en is issued, and the block resumes in IDLE.
// TESTING  (Q_BITS=10, D_BITS=32; 1.0 = 1024)
//  1. Basic:
//     O=(0,0,0), D=(0,0,1024), N=(0,0,1024), P0=(0,0,5120)
//     -> one out_wr_en at T+8; num=5120, den=1024, parallel=0
//  2. Signs:
//     D=(0,0,-1024), O=(0,0,7168), rest as test 1
//     -> num=-2048, den=-1024, parallel=0
//  3. Parallel ray:
//     D=(1024,0,0), N=(0,0,1024), P0=(0,0,5120)
//     -> den=0, parallel=1, num=5120, record still written
//  4. Saturation:
//     N=(0x40000000,0,0), D=(0x40000000,0,0), P0=(0x40000000,0,0), O=0
//     -> num=den=0x7FFFFFFF
//     Negating N gives num=den=0x80000001
//  5. Backpressure:
//     out_full=1 for 5 cycles during WRITE, in_empty=0 throughout
//     -> outputs stable, no in_rd_en, single out_wr_en on the release cycle
//  6. Reset at MAC k=3, then replay test 1
//     -> no out_wr_en from the aborted record; replay gives num=5120, den=1024

Source files
------------

// File: rtl/ray_plane_num_den.sv
// Operand stage ahead of the divider: pops a ray/plane record, forms num = N.(P0-O) and den = N.D
// on one shared signed multiplier (SUB + 6 MAC cycles), then pushes the saturated pair downstream.
module ray_plane_num_den #(
    parameter int Q_BITS = 10,
    parameter int D_BITS = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3*D_BITS-1:0]   ray_o,
    input  logic [3*D_BITS-1:0]   ray_d,
    input  logic [3*D_BITS-1:0]   pln_n,
    input  logic [3*D_BITS-1:0]   pln_p,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [D_BITS-1:0]     num_out,
    output logic [D_BITS-1:0]     den_out,
    output logic                  parallel,
    input  logic                  out_full,
    output logic                  out_wr_en
);

    localparam int P_BITS = 2*D_BITS + 1;
    localparam int A_BITS = 2*D_BITS + 3;
    localparam logic signed [A_BITS-1:0] SAT_HI = {{(A_BITS-D_BITS+1){1'b0}}, {(D_BITS-1){1'b1}}};
    localparam logic signed [A_BITS-1:0] SAT_LO = -SAT_HI;

    typedef enum logic [1:0] {IDLE, SUB, MAC, WRITE} state_t;

    state_t state;
    state_t state_next;

    logic [3*D_BITS-1:0]      o_vec;
    logic [3*D_BITS-1:0]      d_vec;
    logic [3*D_BITS-1:0]      n_vec;
    logic [3*D_BITS-1:0]      p_vec;
    logic signed [D_BITS:0]   diff [3];
    logic [2:0]               k;
    logic signed [A_BITS-1:0] acc_num;
    logic signed [A_BITS-1:0] acc_den;

    logic signed [D_BITS-1:0] n_c [3];
    logic signed [D_BITS-1:0] d_c [3];
    logic signed [D_BITS-1:0] o_c [3];
    logic signed [D_BITS-1:0] p_c [3];
    logic signed [P_BITS-1:0] mul_a;
    logic signed [P_BITS-1:0] mul_b;
    logic signed [P_BITS-1:0] product;
    logic [D_BITS-1:0]        num_sat;
    logic [D_BITS-1:0]        den_sat;

    function automatic logic signed [P_BITS-1:0] ext_d(input logic signed [D_BITS-1:0] v);
        return {{(P_BITS-D_BITS){v[D_BITS-1]}}, v};
    endfunction

    function automatic logic signed [P_BITS-1:0] ext_diff(input logic signed [D_BITS:0] v);
        return {{(P_BITS-D_BITS-1){v[D_BITS]}}, v};
    endfunction

    function automatic logic signed [A_BITS-1:0] ext_p(input logic signed [P_BITS-1:0] v);
        return {{(A_BITS-P_BITS){v[P_BITS-1]}}, v};
    endfunction

    // Symmetric clamp: the most negative code is excluded so the divider can always negate.
    function automatic logic [D_BITS-1:0] saturate(input logic signed [A_BITS-1:0] acc);
        logic signed [A_BITS-1:0] r;
        r = acc >>> Q_BITS;
        if (r > SAT_HI) begin
            return SAT_HI[D_BITS-1:0];
        end else if (r < SAT_LO) begin
            return SAT_LO[D_BITS-1:0];
        end else begin
            return r[D_BITS-1:0];
        end
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            n_c[i] = n_vec[i*D_BITS +: D_BITS];
            d_c[i] = d_vec[i*D_BITS +: D_BITS];
            o_c[i] = o_vec[i*D_BITS +: D_BITS];
            p_c[i] = p_vec[i*D_BITS +: D_BITS];
        end
    end

    // k = 0..2 walks N against the difference vector, k = 3..5 walks N against D.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (k)
            3'd0: begin mul_a = ext_d(n_c[0]); mul_b = ext_diff(diff[0]); end
            3'd1: begin mul_a = ext_d(n_c[1]); mul_b = ext_diff(diff[1]); end
            3'd2: begin mul_a = ext_d(n_c[2]); mul_b = ext_diff(diff[2]); end
            3'd3: begin mul_a = ext_d(n_c[0]); mul_b = ext_d(d_c[0]);     end
            3'd4: begin mul_a = ext_d(n_c[1]); mul_b = ext_d(d_c[1]);     end
            3'd5: begin mul_a = ext_d(n_c[2]); mul_b = ext_d(d_c[2]);     end
            default: begin end
        endcase
    end

    assign product = mul_a * mul_b;
    assign num_sat = saturate(acc_num);
    assign den_sat = saturate(acc_den);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!in_empty) state_next = SUB;
            SUB:     state_next = MAC;
            MAC:     if (k == 3'd5) state_next = WRITE;
            WRITE:   if (!out_full) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes are also held low while reset is asserted, independent of the input FIFO level.
    always_comb begin
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;
        num_out   = '0;
        den_out   = '0;
        parallel  = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: in_rd_en = !in_empty;
                WRITE: begin
                    num_out   = num_sat;
                    den_out   = den_sat;
                    parallel  = (den_sat == '0);
                    out_wr_en = !out_full;
                end
                default: begin end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            o_vec   <= '0;
            d_vec   <= '0;
            n_vec   <= '0;
            p_vec   <= '0;
            k       <= '0;
            acc_num <= '0;
            acc_den <= '0;
            for (int i = 0; i < 3; i++) begin
                diff[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (!in_empty) begin
                        o_vec <= ray_o;
                        d_vec <= ray_d;
                        n_vec <= pln_n;
                        p_vec <= pln_p;
                    end
                end
                SUB: begin
                    for (int i = 0; i < 3; i++) begin
                        diff[i] <= {p_c[i][D_BITS-1], p_c[i]} - {o_c[i][D_BITS-1], o_c[i]};
                    end
                    acc_num <= '0;
                    acc_den <= '0;
                    k       <= '0;
                end
                MAC: begin
                    if (k < 3'd3) begin
                        acc_num <= acc_num + ext_p(product);
                    end else begin
                        acc_den <= acc_den + ext_p(product);
                    end
                    k <= k + 3'd1;
                end
                default: begin end
            endcase
        end
    end

endmodule

// File: tb/tb_ray_plane_num_den.sv
// Bench for ray_plane_num_den: directed cases and random records against a wide-integer dot-product model.
module tb_ray_plane_num_den;

    logic        clock = 1'b0;
    logic        reset;
    logic [95:0] ray_o, ray_d, pln_n, pln_p;
    logic        in_empty;
    logic        in_rd_en;
    logic [31:0] num_out, den_out;
    logic        parallel;
    logic        out_full;
    logic        out_wr_en;

    int n_vec = 0;
    int n_bad = 0;

    ray_plane_num_den #(.Q_BITS(10), .D_BITS(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .ray_o    (ray_o),
        .ray_d    (ray_d),
        .pln_n    (pln_n),
        .pln_p    (pln_p),
        .in_empty (in_empty),
        .in_rd_en (in_rd_en),
        .num_out  (num_out),
        .den_out  (den_out),
        .parallel (parallel),
        .out_full (out_full),
        .out_wr_en(out_wr_en)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [95:0] vec3(input int x, input int y, input int z);
        return {z, y, x};
    endfunction

    function automatic logic signed [127:0] sx(input logic [31:0] v);
        return {{96{v[31]}}, v};
    endfunction

    function automatic logic [31:0] clamp(input logic signed [127:0] acc);
        logic signed [127:0] r;
        r = acc >>> 10;
        if (r > 128'sd2147483647)       return 32'h7FFF_FFFF;
        else if (r < -128'sd2147483647) return 32'h8000_0001;
        else                            return r[31:0];
    endfunction

    // Exact dot products in 128-bit integers, then floor-shift and clamp.
    task automatic model(input logic [95:0] o, input logic [95:0] d, input logic [95:0] n,
                         input logic [95:0] p, output logic [31:0] num, output logic [31:0] den,
                         output logic par);
        logic signed [127:0] an, ad;
        an = '0;
        ad = '0;
        for (int i = 0; i < 3; i++) begin
            an += sx(n[i*32 +: 32]) * (sx(p[i*32 +: 32]) - sx(o[i*32 +: 32]));
            ad += sx(n[i*32 +: 32]) * sx(d[i*32 +: 32]);
        end
        num = clamp(an);
        den = clamp(ad);
        par = (den == 32'd0);
    endtask

    task automatic wait_pop(input logic [95:0] o, input logic [95:0] d, input logic [95:0] n,
                            input logic [95:0] p);
        int c;
        @(negedge clock);
        ray_o = o; ray_d = d; pln_n = n; pln_p = p;
        in_empty = 1'b0;
        out_full = 1'b0;
        #1;
        c = 0;
        while (!in_rd_en && c < 20) begin
            @(negedge clock);
            #1;
            c++;
        end
        check("pop", in_rd_en, 1'b1);
    endtask

    task automatic run_record(input logic [95:0] o, input logic [95:0] d, input logic [95:0] n,
                              input logic [95:0] p, input int hold, input bit keep_avail);
        logic [31:0] en, ed;
        logic        ep;
        model(o, d, n, p, en, ed, ep);
        wait_pop(o, d, n, p);
        for (int cy = 1; cy <= 8 + hold; cy++) begin
            @(negedge clock);
            if (!keep_avail) in_empty = 1'b1;
            out_full = (cy >= 8 && cy < 8 + hold);
            #1;
            check("no_pop", in_rd_en, 1'b0);
            if (cy < 8 + hold) check("no_push", out_wr_en, 1'b0);
            if (cy < 8) begin
                check("num_zero", num_out, 32'd0);
                check("den_zero", den_out, 32'd0);
            end else begin
                check("num", num_out, en);
                check("den", den_out, ed);
                check("parallel", parallel, ep);
            end
            if (cy == 8 + hold) check("push", out_wr_en, 1'b1);
        end
        in_empty = 1'b1;
        out_full = 1'b0;
    endtask

    function automatic int rnd(input int mode);
        if (mode == 0) return int'($urandom_range(0, 2097152)) - 1048576;
        return int'($urandom);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [95:0] o, d, n, p;
        int mode;

        reset = 1'b1; in_empty = 1'b0; out_full = 1'b0;
        ray_o = '1; ray_d = '1; pln_n = '1; pln_p = '1;
        #3;
        check("rst_rd_en", in_rd_en, 1'b0);
        check("rst_wr_en", out_wr_en, 1'b0);
        check("rst_num", num_out, 32'd0);
        check("rst_den", den_out, 32'd0);
        check("rst_parallel", parallel, 1'b0);
        @(negedge clock);
        @(negedge clock);
        in_empty = 1'b1;
        reset = 1'b0;

        // basic, signs, parallel ray, positive and negative saturation
        run_record(vec3(0, 0, 0), vec3(0, 0, 1024), vec3(0, 0, 1024), vec3(0, 0, 5120), 0, 1'b0);
        run_record(vec3(0, 0, 7168), vec3(0, 0, -1024), vec3(0, 0, 1024), vec3(0, 0, 5120), 0, 1'b0);
        run_record(vec3(0, 0, 0), vec3(1024, 0, 0), vec3(0, 0, 1024), vec3(0, 0, 5120), 0, 1'b0);
        run_record(vec3(0, 0, 0), vec3(32'h4000_0000, 0, 0), vec3(32'h4000_0000, 0, 0),
                   vec3(32'h4000_0000, 0, 0), 0, 1'b0);
        run_record(vec3(0, 0, 0), vec3(32'h4000_0000, 0, 0), vec3(-32'sh4000_0000, 0, 0),
                   vec3(32'h4000_0000, 0, 0), 0, 1'b0);

        // backpressure with another record already waiting
        run_record(vec3(0, 0, 0), vec3(0, 0, 1024), vec3(0, 0, 1024), vec3(0, 0, 5120), 5, 1'b1);

        // reset while the MAC is at k=3, then replay
        wait_pop(vec3(0, 0, 0), vec3(0, 0, 1024), vec3(0, 0, 1024), vec3(0, 0, 5120));
        for (int cy = 1; cy <= 5; cy++) begin
            @(negedge clock);
            in_empty = 1'b1;
            #1;
            check("abort_no_push", out_wr_en, 1'b0);
        end
        reset = 1'b1;
        #1;
        check("abort_rst_wr", out_wr_en, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        for (int cy = 0; cy < 12; cy++) begin
            @(negedge clock);
            #1;
            check("abort_quiet", out_wr_en, 1'b0);
        end
        run_record(vec3(0, 0, 0), vec3(0, 0, 1024), vec3(0, 0, 1024), vec3(0, 0, 5120), 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            mode = int'($urandom_range(0, 3));
            if (mode == 3) begin
                o = vec3(rnd(0), rnd(0), rnd(0));
                p = vec3(rnd(0), rnd(0), rnd(0));
                n = vec3(0, 0, rnd(1));
                d = vec3(rnd(1), rnd(1), 0);
            end else begin
                if (mode == 2) mode = 0;
                o = vec3(rnd(mode), rnd(mode), rnd(mode));
                d = vec3(rnd(mode), rnd(mode), rnd(mode));
                n = vec3(rnd(mode), rnd(mode), rnd(mode));
                p = vec3(rnd(mode), rnd(mode), rnd(mode));
            end
            run_record(o, d, n, p, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
